sdp_ram_ctl: RTL and testbench



---
 rtl/sdp_ram_ctl.sv | 172 +++++++++++++++++
 tb/tb_sdp_ram_ctl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_ctl.sv
// sdp_ram_ctl
//   Single-clock simple dual-port RAM with byte-lane write enables, an
//   optional output register, selectable read-during-write behaviour, a
//   read-valid pipeline and an optional clear-on-reset sequencer.
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset
//   DI        in   write data
//   WRADDR    in   write address
//   WREN      in   write port enable
//   WE        in   per-lane write enable (qualified by WREN)
//   RDADDR    in   read address
//   RDEN      in   read port enable
//   REGCE     in   output register clock enable (DO_REG=1 only)
//   DO        out  read data
//   DO_VALID  out  DO holds data from an accepted read
//   BUSY      out  clear sequence running; both ports blocked
module sdp_ram_ctl #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 11,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    DO_REG       = 1,
    parameter                        RDW_MODE     = "READ_FIRST",
    parameter int                    CLEAR_ON_RST = 0,
    parameter logic [DATA_WIDTH-1:0] SRVAL        = '0
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [DATA_WIDTH-1:0]            DI,
    input  logic [ADDR_WIDTH-1:0]            WRADDR,
    input  logic                             WREN,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE,
    input  logic [ADDR_WIDTH-1:0]            RDADDR,
    input  logic                             RDEN,
    input  logic                             REGCE,
    output logic [DATA_WIDTH-1:0]            DO,
    output logic                             DO_VALID,
    output logic                             BUSY
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int NB       = DATA_WIDTH / BYTE_WIDTH;
    localparam bit WR_FIRST = (RDW_MODE == "WRITE_FIRST");

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy;
    logic                  clr_we;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (CLEAR_ON_RST == 0) begin
            state_d = IDLE;
        end else if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = IDLE;   // last address being written
        end
    end

    always_comb begin
        busy   = (state_q == CLEAR);
        clr_we = busy && !RST;            // no clear writes while RST held
    end

    assign BUSY = busy;

    // ---------------- write port ----------------
    logic                  wr_acc, rd_acc;
    logic [NB-1:0]         wr_lane;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign wr_acc = WREN && !busy && !RST;
    assign rd_acc = RDEN && !busy && !RST;

    // Clear sequencer and user port share one physical write port; the
    // user port is blocked while busy, so they never compete.
    always_comb begin
        wr_lane = '0;
        wr_addr = WRADDR;
        wr_data = DI;
        if (clr_we) begin
            wr_lane = '1;
            wr_addr = cnt_q;
            wr_data = SRVAL;
        end else if (wr_acc) begin
            wr_lane = WE;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lane[i])
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // ---------------- read stage 1 ----------------
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  vld1_q, vld1_d;

    always_comb begin
        rd_d   = rd_q;
        vld1_d = rd_acc;
        if (rd_acc) begin
            rd_d = mem[RDADDR];
            // Write-first bypass: merge the enabled DI lanes over the old word.
            if (WR_FIRST && wr_acc && (RDADDR == WRADDR)) begin
                for (int i = 0; i < NB; i++) begin
                    if (WE[i]) rd_d[i*BYTE_WIDTH +: BYTE_WIDTH] = DI[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q   <= SRVAL;
            vld1_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            vld1_q <= vld1_d;
        end
    end

    // ---------------- output stage ----------------
    generate
        if (DO_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] do_q, do_d;
            logic                  vld2_q, vld2_d;

            always_comb begin
                do_d   = REGCE ? rd_q   : do_q;
                vld2_d = REGCE ? vld1_q : vld2_q;
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    do_q   <= SRVAL;
                    vld2_q <= 1'b0;
                end else begin
                    do_q   <= do_d;
                    vld2_q <= vld2_d;
                end
            end

            assign DO       = do_q;
            assign DO_VALID = vld2_q;
        end else begin : g_noreg
            assign DO       = rd_q;
            assign DO_VALID = vld1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_ctl.sv
module tb_sdp_ram_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wren, wren_x, rden, rden_x, regce;
    logic [1:0]  we;
    logic [3:0]  wa, ra;
    logic [15:0] di;
    logic [15:0] rf_do, wf_do, d0_do;
    logic        rf_v, wf_v, d0_v, rf_b, wf_b, d0_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Read-first, registered output, clear-on-reset with 0xDEAD.
    sdp_ram_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .DO_REG(1),
                  .RDW_MODE("READ_FIRST"), .CLEAR_ON_RST(1), .SRVAL(16'hDEAD)) u_rf (
        .CLK(clk), .RST(rst), .DI(di), .WRADDR(wa), .WREN(wren | wren_x), .WE(we),
        .RDADDR(ra), .RDEN(rden | rden_x), .REGCE(regce),
        .DO(rf_do), .DO_VALID(rf_v), .BUSY(rf_b));

    // Write-first, registered output, no clear.
    sdp_ram_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .DO_REG(1),
                  .RDW_MODE("WRITE_FIRST"), .CLEAR_ON_RST(0), .SRVAL(16'h0000)) u_wf (
        .CLK(clk), .RST(rst), .DI(di), .WRADDR(wa), .WREN(wren), .WE(we),
        .RDADDR(ra), .RDEN(rden), .REGCE(regce),
        .DO(wf_do), .DO_VALID(wf_v), .BUSY(wf_b));

    // Read-first, unregistered output, no clear.
    sdp_ram_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .DO_REG(0),
                  .RDW_MODE("READ_FIRST"), .CLEAR_ON_RST(0), .SRVAL(16'h0000)) u_d0 (
        .CLK(clk), .RST(rst), .DI(di), .WRADDR(wa), .WREN(wren), .WE(we),
        .RDADDR(ra), .RDEN(rden), .REGCE(regce),
        .DO(d0_do), .DO_VALID(d0_v), .BUSY(d0_b));

    typedef struct {
        logic        wren;
        logic [1:0]  we;
        logic [3:0]  wa;
        logic [15:0] di;
        logic        rden;
        logic [3:0]  ra;
        logic        regce;
        logic        rv; logic [15:0] rd;   // u_rf expected
        logic        wv; logic [15:0] wd;   // u_wf expected
        logic        dv; logic [15:0] dd;   // u_d0 expected
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic wr, input logic [1:0] w, input logic [3:0] a,
                                input logic [15:0] d, input logic rd, input logic [3:0] r,
                                input logic ce, input logic rv, input logic [15:0] rdat,
                                input logic wv, input logic [15:0] wdat,
                                input logic dv, input logic [15:0] ddat);
        vec_t v;
        v.wren = wr; v.we = w; v.wa = a; v.di = d;
        v.rden = rd; v.ra = r; v.regce = ce;
        v.rv = rv; v.rd = rdat; v.wv = wv; v.wd = wdat; v.dv = dv; v.dd = ddat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        // addr 3=ABCD, 5=1234 then FF34, 7=0001 then collisions
        tbl[0]  = mk(1, 2'b11, 3, 16'hABCD, 0, 0, 1, 0, 0,        0, 0,        0, 0);
        tbl[1]  = mk(1, 2'b11, 5, 16'h1234, 1, 3, 1, 0, 0,        0, 0,        1, 16'hABCD);
        tbl[2]  = mk(1, 2'b10, 5, 16'hFF00, 0, 0, 1, 1, 16'hABCD, 1, 16'hABCD, 0, 0);
        tbl[3]  = mk(0, 0,     0, 0,        1, 5, 1, 0, 0,        0, 0,        1, 16'hFF34);
        tbl[4]  = mk(1, 2'b11, 7, 16'h0001, 0, 0, 1, 1, 16'hFF34, 1, 16'hFF34, 0, 0);
        tbl[5]  = mk(1, 2'b11, 7, 16'h00AA, 1, 7, 1, 0, 0,        0, 0,        1, 16'h0001);
        tbl[6]  = mk(0, 0,     0, 0,        1, 7, 1, 1, 16'h0001, 1, 16'h00AA, 1, 16'h00AA);
        tbl[7]  = mk(0, 0,     0, 0,        0, 0, 1, 1, 16'h00AA, 1, 16'h00AA, 0, 0);
        tbl[8]  = mk(1, 2'b01, 7, 16'h5566, 1, 7, 1, 0, 0,        0, 0,        1, 16'h00AA);
        tbl[9]  = mk(0, 0,     0, 0,        0, 0, 1, 1, 16'h00AA, 1, 16'h0066, 0, 0);
        tbl[10] = mk(0, 0,     0, 0,        1, 7, 1, 0, 0,        0, 0,        1, 16'h0066);
        tbl[11] = mk(0, 0,     0, 0,        0, 0, 1, 1, 16'h0066, 1, 16'h0066, 0, 0);
        tbl[12] = mk(0, 0,     0, 0,        1, 3, 1, 0, 0,        0, 0,        1, 16'hABCD);
        tbl[13] = mk(0, 0,     0, 0,        1, 5, 1, 1, 16'hABCD, 1, 16'hABCD, 1, 16'hFF34);
        tbl[14] = mk(0, 0,     0, 0,        1, 7, 1, 1, 16'hFF34, 1, 16'hFF34, 1, 16'h0066);
        tbl[15] = mk(0, 0,     0, 0,        0, 0, 1, 1, 16'h0066, 1, 16'h0066, 0, 0);
        tbl[16] = mk(0, 0,     0, 0,        1, 5, 1, 0, 0,        0, 0,        1, 16'hFF34);
        tbl[17] = mk(0, 0,     0, 0,        1, 3, 1, 1, 16'hFF34, 1, 16'hFF34, 1, 16'hABCD);
        tbl[18] = mk(0, 0,     0, 0,        0, 0, 0, 1, 16'hFF34, 1, 16'hFF34, 0, 0);

        rst = 1; wren = 0; wren_x = 0; rden = 0; rden_x = 0; regce = 1;
        we = 0; wa = 0; ra = 0; di = 0;
        tick(); tick();

        // reset state
        chk("rst rf_do",   rf_do, 16'hDEAD);
        chk("rst rf_v",    rf_v,  0);
        chk("rst rf_busy", rf_b,  1);
        chk("rst wf_do",   wf_do, 0);
        chk("rst wf_busy", wf_b,  0);
        chk("rst d0_v",    d0_v,  0);

        // clear sequence: write and read attempts during BUSY must be dropped
        rst = 0; wren_x = 1; we = 2'b11; wa = 0; di = 16'h1234; rden_x = 1; ra = 0;
        n = 0;
        while (rf_b && n < 100) begin
            tick();
            n++;
            chk("busy rf_v", rf_v, 0);
        end
        chk("clear cycles", n, 16);
        wren_x = 0; rden_x = 0; we = 0; di = 0;

        for (int a = 0; a < 16; a++) begin
            rden = 1; ra = a[3:0];
            tick();
            if (a > 0) begin
                chk($sformatf("clr rd%0d do", a - 1), rf_do, 16'hDEAD);
                chk($sformatf("clr rd%0d v", a - 1), rf_v, 1);
            end
        end
        rden = 0; ra = 0;
        tick();
        chk("clr rd15 do", rf_do, 16'hDEAD);
        tick();

        // directed vectors
        for (int i = 0; i < 19; i++) begin
            wren = tbl[i].wren; we = tbl[i].we; wa = tbl[i].wa; di = tbl[i].di;
            rden = tbl[i].rden; ra = tbl[i].ra; regce = tbl[i].regce;
            tick();
            chk($sformatf("v%0d rf_v", i), rf_v, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("v%0d rf_do", i), rf_do, tbl[i].rd);
            chk($sformatf("v%0d wf_v", i), wf_v, tbl[i].wv);
            if (tbl[i].wv) chk($sformatf("v%0d wf_do", i), wf_do, tbl[i].wd);
            chk($sformatf("v%0d d0_v", i), d0_v, tbl[i].dv);
            if (tbl[i].dv) chk($sformatf("v%0d d0_do", i), d0_do, tbl[i].dd);
        end

        // REGCE raised after a held cycle: held stage-1 word moves out,
        // valid is not carried since no read was accepted in between
        wren = 0; rden = 0; regce = 1;
        tick();
        chk("regce rf_do", rf_do, 16'hABCD);
        chk("regce rf_v",  rf_v,  0);
        chk("regce wf_do", wf_do, 16'hABCD);

        // reset in the middle of a clear restarts it
        rst = 1;
        tick();
        rst = 0;
        repeat (9) tick();
        chk("mid busy", rf_b, 1);
        rst = 1;
        tick();
        chk("mid rst do",   rf_do, 16'hDEAD);
        chk("mid rst v",    rf_v,  0);
        chk("mid rst busy", rf_b,  1);
        chk("mid rst wf_do", wf_do, 0);
        rst = 0;
        n = 0;
        while (rf_b && n < 100) begin
            tick();
            n++;
        end
        chk("mid clear cycles", n, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
